// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader.
//   - IMEM_DEPTH_WORDS : default instruction memory depth in 32-bit words
//   - IMEM_WORD_W      : instruction word width
//   - ST_*             : loader FSM state encodings (3-bit)
package imem_pkg;

  localparam int IMEM_DEPTH_WORDS = 1024;
  localparam int IMEM_WORD_W      = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CKSUM = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: collects bytes into little-endian 32-bit words.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        restart word assembly at byte 0
//   i_valid        i_byte is consumed this cycle
//   i_byte         incoming byte
//   o_word_valid   high in the cycle the 4th byte of a word is consumed
//   o_word         assembled word (valid together with o_word_valid)
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [7:0]             i_byte,
  output logic                   o_word_valid,
  output logic [IMEM_WORD_W-1:0] o_word
);

  // Only three bytes are ever held; the 4th is taken straight from i_byte
  // so the word is available in the same cycle as its last handshake.
  logic [23:0] r_shreg;
  logic [1:0]  r_cnt;

  assign o_word_valid = i_valid && (r_cnt == 2'd3);
  assign o_word       = {i_byte, r_shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      // Shift right so the oldest byte ends up in bits [7:0].
      r_shreg <= {i_byte, r_shreg[23:8]};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a byte-stream image into instruction memory and holds
// the CPU in reset until the image is complete.
// Stream format: count[7:0], count[15:8], then count words little-endian.
// Optional macro IMEM_LOADER_CKSUM_EN: one trailing byte must equal the XOR
// of all header and data bytes.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse, starts a session when not busy
//   in_data/in_valid/in_ready  byte stream; a byte moves when both are high
//                        at a rising edge. in_ready depends only on state.
//   we/waddr/wdata       memory write port, one-cycle we pulse per word
//   busy/done/error      session status (done/error sticky until start)
//   cpu_hold             CPU reset request, active high
//   dbg_state            current FSM state (ST_* encoding)
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH_WORDS,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   we,
  output logic [AW-1:0]          waddr,
  output logic [IMEM_WORD_W-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   cpu_hold,
  output logic [2:0]             dbg_state
);

`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] ST_AFTER   = ST_CKSUM;
  localparam logic       ENTER_DONE = 1'b0;
`else
  localparam logic [2:0] ST_AFTER   = ST_DONE;
  localparam logic       ENTER_DONE = 1'b1;
`endif

  logic [2:0]             r_state;
  logic [15:0]            r_count;
  logic [15:0]            r_word_idx;
  logic                   r_we;
  logic [AW-1:0]          r_waddr;
  logic [IMEM_WORD_W-1:0] r_wdata;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic                   r_cpu_hold;

  logic                   w_accept;
  logic                   w_session_start;
  logic [15:0]            w_count;
  logic                   w_count_gt;
  logic                   w_last_word;
  logic                   w_word_valid;
  logic [IMEM_WORD_W-1:0] w_word;

  assign in_ready = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                    (r_state == ST_DATA) || (r_state == ST_CKSUM);
  assign w_accept = in_valid && in_ready;
  // start is only honoured when no session is running.
  assign w_session_start = start && ((r_state == ST_IDLE) ||
                           (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_count     = {in_data, r_count[7:0]};
  assign w_count_gt  = {1'b0, w_count} > 17'(DEPTH);
  assign w_last_word = (r_word_idx == (r_count - 16'd1));

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_session_start),
    .i_valid      (w_accept && (r_state == ST_DATA)),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor <= '0;
    end else if (w_session_start) begin
      r_xor <= '0;
    end else if (w_accept && (r_state != ST_CKSUM)) begin
      r_xor <= r_xor ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_session_start) begin
            r_state    <= ST_HDR0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
          end
        end
        ST_HDR0: begin
          if (w_accept) begin
            r_count[7:0] <= in_data;
            r_state      <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_accept) begin
            r_count[15:8] <= in_data;
            r_word_idx    <= '0;
            if (w_count_gt) begin
              r_state <= ST_ERR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= ST_AFTER;
              if (ENTER_DONE) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_valid) begin
            r_we       <= 1'b1;
            r_wdata    <= w_word;
            r_waddr    <= AW'({r_word_idx, 2'b00});
            r_word_idx <= r_word_idx + 16'd1;
            if (w_last_word) begin
              r_state <= ST_AFTER;
              if (ENTER_DONE) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end
            end
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (w_accept) begin
            r_busy <= 1'b0;
            if (in_data == r_xor) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              // Words are already in memory, but the CPU stays held.
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign cpu_hold  = r_cpu_hold;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        mark4 = 1'b0;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  int          hs_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  img_q[$];
  int          img_words;

  imem_loader #(.DEPTH(1024), .AW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_hold  (cpu_hold),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Monitor: logs every write and every 4th-byte handshake with a cycle stamp.
  always @(posedge clk) begin
    if (we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
    end
    if (in_valid && in_ready && mark4) hs_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    hs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic img_begin(input logic [15:0] cnt);
    img_q.delete();
    img_q.push_back(cnt[7:0]);
    img_q.push_back(cnt[15:8]);
    img_words = 0;
  endtask

  task automatic img_word(input logic [31:0] w);
    img_q.push_back(w[7:0]);
    img_q.push_back(w[15:8]);
    img_q.push_back(w[23:16]);
    img_q.push_back(w[31:24]);
    img_words++;
    exp_q.push_back(w);
  endtask

  task automatic img_cksum(input logic good);
    logic [7:0] x;
    x = 8'h00;
    foreach (img_q[i]) x = x ^ img_q[i];
    img_q.push_back(good ? x : (x ^ 8'h01));
  endtask

  // Appends the trailer only when the checksum option is built in.
  task automatic img_end();
`ifdef IMEM_LOADER_CKSUM_EN
    img_cksum(1'b1);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic w4, input logic rnd);
    int guard;
    guard = 0;
    if (rnd) begin
      while (($urandom_range(0, 1) == 0) && (guard < 20)) begin
        in_valid = 1'b0;
        tick();
        guard++;
      end
    end
    in_data = b;
    mark4 = w4;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && (guard < 50)) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout in_ready=%0b required=1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    mark4 = 1'b0;
  endtask

  task automatic send_image(input logic rnd);
    for (int i = 0; i < img_q.size(); i++)
      send_byte(img_q[i], (i >= 2) && (i < 2 + 4 * img_words) && (((i - 2) % 4) == 3), rnd);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && (g < 300)) begin
      tick();
      g++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle busy=%0b required=0", busy);
    end
    tick();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold got=%0b exp=1", cpu_hold); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", we); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_err_busy got=%0b%0b exp=00", error, busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    checks++; if (waddr !== 32'h0 || wdata !== 32'h0) begin failures++; $display("FAIL rst_wport got=%h/%h exp=0/0", waddr, wdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (dbg_state !== 3'd0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL idle_state got=%0d/%0b/%0b exp=0/1/0", dbg_state, cpu_hold, done);
    end
  endtask

  task automatic check_writes(input string name);
    checks++;
    if (wd_q.size() != exp_q.size()) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", name, wd_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wd_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL %s_w%0d got=%h:%h exp=%h:%h", name, i, wa_q[i], wd_q[i], 32'(i * 4), exp_q[i]);
      end
    end
  endtask

  task automatic check_latency(input string name);
    checks++;
    if (hs_q.size() != wc_q.size()) begin
      failures++; $display("FAIL %s_lat_count got=%0d exp=%0d", name, wc_q.size(), hs_q.size());
    end
    for (int i = 0; i < hs_q.size() && i < wc_q.size(); i++) begin
      checks++;
      if (wc_q[i] != hs_q[i] + 1) begin
        failures++; $display("FAIL %s_lat%0d got=%0d exp=%0d", name, i, wc_q[i], hs_q[i] + 1);
      end
    end
  endtask

  task automatic test_basic();
    clear_logs();
    img_begin(16'd2); img_word(32'h0000_0013); img_word(32'h0000_006F); img_end();
    pulse_start();
    send_image(1'b0);
    wait_idle();
    check_writes("basic");
    check_latency("basic");
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL basic_status got=d%0b h%0b e%0b exp=d1 h0 e0", done, cpu_hold, error);
    end
    // Bytes offered in DONE must not be taken or written.
    in_data = 8'hAA; in_valid = 1'b1;
    tick(); tick(); tick();
    checks++; if (in_ready !== 1'b0 || wd_q.size() != 2) begin
      failures++; $display("FAIL done_no_accept got=r%0b n%0d exp=r0 n2", in_ready, wd_q.size());
    end
    in_valid = 1'b0;
    tick();
    // waddr holds its last value between writes.
    checks++; if (waddr !== 32'h4 || wdata !== 32'h6F) begin
      failures++; $display("FAIL hold_wport got=%h:%h exp=00000004:0000006f", waddr, wdata);
    end
  endtask

  task automatic test_random_valid();
    clear_logs();
    img_begin(16'd2); img_word(32'h0000_0013); img_word(32'h0000_006F); img_end();
    pulse_start();
    send_image(1'b1);
    wait_idle();
    check_writes("rand");
    check_latency("rand");
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rand_done got=%0b exp=1", done); end
  endtask

  task automatic test_oversize();
    clear_logs();
    img_begin(16'd1025);
    pulse_start();
    send_image(1'b0);
    tick(); tick();
    checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL oversize_status got=e%0b h%0b d%0b b%0b exp=e1 h1 d0 b0", error, cpu_hold, done, busy);
    end
    checks++; if (wd_q.size() != 0) begin failures++; $display("FAIL oversize_writes got=%0d exp=0", wd_q.size()); end
    clear_logs();
    img_begin(16'd2); img_word(32'h0000_0013); img_word(32'h0000_006F); img_end();
    pulse_start();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL restart_clear got=e%0b b%0b exp=e0 b1", error, busy);
    end
    send_image(1'b0);
    wait_idle();
    check_writes("recover");
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL recover_status got=d%0b e%0b exp=d1 e0", done, error); end
  endtask

  task automatic test_zero_count();
    clear_logs();
    img_begin(16'd0); img_end();
    pulse_start();
    send_image(1'b0);
    wait_idle();
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || wd_q.size() != 0) begin
      failures++; $display("FAIL zero_done got=d%0b h%0b n%0d exp=d1 h0 n0", done, cpu_hold, wd_q.size());
    end
`ifdef IMEM_LOADER_CKSUM_EN
    clear_logs();
    img_begin(16'd0); img_cksum(1'b0);
    pulse_start();
    send_image(1'b0);
    wait_idle();
    checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL cksum_bad got=e%0b d%0b h%0b exp=e1 d0 h1", error, done, cpu_hold);
    end
    clear_logs();
    img_begin(16'd1); img_word(32'hCAFE_F00D); img_cksum(1'b0);
    pulse_start();
    send_image(1'b0);
    wait_idle();
    check_writes("cksum_bad_data");
    checks++; if (error !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL cksum_bad_data got=e%0b h%0b exp=e1 h1", error, cpu_hold);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_logs();
    img_begin(16'd3); img_word(32'h1122_3344); img_word(32'hA5A5_A5A5); img_word(32'hDEAD_BEEF);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img_q[i], (i == 5), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || we !== 1'b0 ||
                  waddr !== 32'h0 || wdata !== 32'h0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got=b%0b h%0b r%0b w%0b %h:%h exp=b0 h1 r0 w0 0:0",
                           busy, cpu_hold, in_ready, we, waddr, wdata);
    end
    checks++; if (wd_q.size() != 1) begin failures++; $display("FAIL midrst_prewrites got=%0d exp=1", wd_q.size()); end
    clear_logs();
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (wd_q.size() != 0 || dbg_state !== 3'd0) begin
      failures++; $display("FAIL midrst_quiet got=n%0d s%0d exp=n0 s0", wd_q.size(), dbg_state);
    end
    clear_logs();
    img_begin(16'd3); img_word(32'h1122_3344); img_word(32'hA5A5_A5A5); img_word(32'hDEAD_BEEF); img_end();
    pulse_start();
    send_image(1'b0);
    wait_idle();
    check_writes("fresh");
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL fresh_done got=%0b exp=1", done); end
  endtask

  task automatic test_start_busy();
    clear_logs();
    img_begin(16'd2); img_word(32'h0403_0201); img_word(32'h0807_0605); img_end();
    pulse_start();
    send_byte(img_q[0], 1'b0, 1'b0);
    pulse_start();
    send_byte(img_q[1], 1'b0, 1'b0);
    for (int i = 2; i < 6; i++) send_byte(img_q[i], (i == 5), 1'b0);
    pulse_start();
    for (int i = 6; i < img_q.size(); i++) send_byte(img_q[i], (i == 9), 1'b0);
    wait_idle();
    check_writes("startbusy");
    checks++; if (done !== 1'b1 || error !== 1'b0) begin
      failures++; $display("FAIL startbusy_status got=d%0b e%0b exp=d1 e0", done, error);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_valid();
    test_oversize();
    test_zero_count();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream from a host link (UART receiver or debug bridge) and writes 32-bit little-endian words into the instruction memory write port.
- Holds the CPU in reset until a complete image has been written.
- Sits between the host byte link and the instruction memory write port; the CPU fetch path is untouched.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; largest accepted image.
- AW, 32, width of the byte address driven on waddr.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a load session
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts in_data this cycle
- we  output  1  instruction memory write enable, one-cycle pulse per word
- waddr  output  AW  byte address of the word being written (word_index<<2)
- wdata  output  32  assembled word
- busy  output  1  session in progress
- done  output  1  sticky; image loaded successfully
- error  output  1  sticky; session aborted
- cpu_hold  output  1  CPU reset request, active high

Behaviour:
- Reset (async, rst_n=0) values: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, cpu_hold=1. The FSM returns to IDLE. Reset mid-session discards all partial state; no further writes occur.
- Handshake: a byte transfers when in_valid && in_ready on a rising edge. in_ready=1 in states HDR0, HDR1, DATA and CKSUM, and 0 otherwise. The loader never stalls inside an active state.
- FSM states:
  - IDLE: start -> HDR0. In the same edge, clear done/error, set busy=1 and cpu_hold=1.
  - HDR0: the accepted byte becomes count[7:0] -> HDR1.
  - HDR1: the accepted byte becomes count[15:8]. Then:
    - count > DEPTH -> ERR.
    - count == 0 -> DONE, or CKSUM when the optional feature is enabled.
    - otherwise -> DATA with word_index=0 and byte_cnt=0.
  - DATA: bytes are packed little-endian, with the first byte going to wdata[7:0]. On acceptance of the 4th byte of a word:
    - the next cycle drives we=1, wdata=word and waddr=word_index<<2 (write latency is 1 cycle after the 4th handshake);
    - word_index then increments;
    - after word count-1 is written -> DONE, or CKSUM when the optional feature is enabled.
  - DONE: busy=0, done=1, cpu_hold=0. Remains here until start.
  - ERR: busy=0, error=1, cpu_hold=1. No writes. Remains here until start.
- Further rules:
  - start in DONE or ERR behaves as in IDLE.
  - start while busy is ignored.
  - Bytes offered while in_ready=0 are not consumed.
  - we is never asserted outside DATA-originated writes.
  - waddr holds its last value between writes.
  - word_index is 16 bits wide with no wrap; count ≤ DEPTH guarantees waddr < DEPTH*4.
  - Exactly count writes occur per successful session.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined:
  - A running 8-bit XOR is taken over all header and data bytes.
  - After the last data byte, the CKSUM state accepts one byte. Match -> DONE; mismatch -> ERR.
  - Data words are already written on mismatch, but cpu_hold stays 1.
- Undefined: the CKSUM state and XOR register are absent, and the FSM goes directly to DONE.

Decomposition:
- Shared package imem_pkg holds:
  - the FSM state enum (IDLE, HDR0, HDR1, DATA, CKSUM, DONE, ERR);
  - IMEM_DEPTH_WORDS=1024;
  - the word width of 32.
- One natural sub-module, imem_word_packer: a byte-to-word shift register with a 2-bit byte counter, emitting word_valid on the 4th byte.

Test Plan:
- Reset then idle: check cpu_hold=1, we=0, done=0. Then start plus bytes 02 00 | 13 00 00 00 | 6F 00 00 00 -> two we pulses: waddr=0x0, wdata=0x00000013; waddr=0x4, wdata=0x0000006F; done=1; cpu_hold=0.
- in_valid toggled 50% randomly during the same image -> identical writes, each we exactly 1 cycle after the 4th byte handshake.
- Header 01 04 (count=1025) -> error=1, cpu_hold=1, no we pulses; a subsequent start plus valid image -> error clears, done=1.
- Header 00 00 -> done=1 with zero writes (without the macro). With IMEM_LOADER_CKSUM_EN, a trailing 00 -> done; trailing 01 -> error.
- rst_n pulsed low after 6 data bytes of a 3-word image -> outputs return to reset values immediately, no further we, and a fresh session loads correctly from waddr=0.
- start pulsed while busy -> ignored; the session completes with the original count.
